ibex_wb_arbiter: RTL and testbench



---
 rtl/ibex_wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ibex_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_arbiter.sv
// Writeback arbiter: merges execute results and in-order load responses onto RF write port A.
// Optional macro IBEX_WB_FORWARD_EN adds operand forwarding from the skid and output registers.
module ibex_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxLoads  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 ld_issue_i,
  input  logic [4:0]           ld_issue_addr_i,
  output logic                 ld_issue_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 stall_a_o,
  output logic                 stall_b_o,
`ifdef IBEX_WB_FORWARD_EN
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
`endif
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o
);

  localparam int unsigned PW = (MaxLoads > 1) ? $clog2(MaxLoads) : 1;
  localparam int unsigned CW = $clog2(MaxLoads + 1);

  logic [31:0]          r_pending;
  logic [4:0]           r_fifo [MaxLoads];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic                 r_skid_v;
  logic [4:0]           r_skid_a;
  logic [DataWidth-1:0] r_skid_d;
  logic                 r_we;
  logic [4:0]           r_waddr;
  logic [DataWidth-1:0] r_wdata;

  logic       w_rsp;
  logic       w_ld_acc;
  logic       w_ex_acc;
  logic [4:0] w_head;
  logic       w_pend_a;
  logic       w_pend_b;
  logic       w_skid_a;
  logic       w_skid_b;
  logic       w_out_a;
  logic       w_out_b;

  assign waddr_a_o = r_waddr;
  assign wdata_a_o = r_wdata;
  assign we_a_o    = r_we;

  assign w_head   = r_fifo[r_head];
  assign w_rsp    = lsu_rvalid_i && (r_count != '0);
  assign w_ld_acc = ld_issue_i && ld_issue_ready_o;
  assign w_ex_acc = ex_valid_i && ex_ready_o;

  assign ld_issue_ready_o = (r_count < CW'(MaxLoads)) &&
                            !r_pending[ld_issue_addr_i];
  assign ex_ready_o = !r_skid_v &&
                      !(ex_valid_i && r_pending[ex_waddr_i]);

  // Hazard matches for both read ports (x0 never hazards)
  always_comb begin
    w_pend_a = r_pending[raddr_a_i];
    w_pend_b = r_pending[raddr_b_i];
    w_skid_a = (raddr_a_i != 5'd0) && r_skid_v && (r_skid_a == raddr_a_i);
    w_skid_b = (raddr_b_i != 5'd0) && r_skid_v && (r_skid_a == raddr_b_i);
    w_out_a  = (raddr_a_i != 5'd0) && r_we && (r_waddr == raddr_a_i);
    w_out_b  = (raddr_b_i != 5'd0) && r_we && (r_waddr == raddr_b_i);
  end

`ifdef IBEX_WB_FORWARD_EN
  // Forward from output register first, then skid, else register file
  always_comb begin
    stall_a_o = w_pend_a;
    stall_b_o = w_pend_b;
    rdata_a_o = rf_rdata_a_i;
    rdata_b_o = rf_rdata_b_i;
    if (w_out_a)       rdata_a_o = r_wdata;
    else if (w_skid_a) rdata_a_o = r_skid_d;
    if (w_out_b)       rdata_b_o = r_wdata;
    else if (w_skid_b) rdata_b_o = r_skid_d;
  end
`else
  // Any in-flight producer of the operand stalls decode
  always_comb begin
    stall_a_o = w_pend_a | w_skid_a | w_out_a;
    stall_b_o = w_pend_b | w_skid_b | w_out_b;
  end
`endif

  // Load scoreboard, destination FIFO and outstanding count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      for (int i = 0; i < int'(MaxLoads); i++) r_fifo[i] <= '0;
    end else begin
      if (w_rsp) begin
        r_pending[w_head] <= 1'b0;
        r_head <= (r_head == PW'(MaxLoads - 1)) ? '0 : r_head + 1'b1;
      end
      if (w_ld_acc) begin
        if (ld_issue_addr_i != 5'd0) r_pending[ld_issue_addr_i] <= 1'b1;
        r_fifo[r_tail] <= ld_issue_addr_i;
        r_tail <= (r_tail == PW'(MaxLoads - 1)) ? '0 : r_tail + 1'b1;
      end
      if (w_ld_acc && !w_rsp)      r_count <= r_count + 1'b1;
      else if (!w_ld_acc && w_rsp) r_count <= r_count - 1'b1;
    end
  end

  // Write-port selection: load response, then skid, then execute
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_skid_v <= 1'b0;
      r_skid_a <= '0;
      r_skid_d <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else if (w_rsp) begin
      r_we    <= !lsu_err_i && (w_head != 5'd0);
      r_waddr <= w_head;
      r_wdata <= lsu_rdata_i;
      if (w_ex_acc) begin
        r_skid_v <= 1'b1;
        r_skid_a <= ex_waddr_i;
        r_skid_d <= ex_wdata_i;
      end
    end else if (r_skid_v) begin
      r_we     <= (r_skid_a != 5'd0);
      r_waddr  <= r_skid_a;
      r_wdata  <= r_skid_d;
      r_skid_v <= 1'b0;
    end else if (w_ex_acc) begin
      r_we    <= (ex_waddr_i != 5'd0);
      r_waddr <= ex_waddr_i;
      r_wdata <= ex_wdata_i;
    end else begin
      r_we <= 1'b0;
    end
  end

  a_rsp_without_load: assert property (
    @(posedge clk_i) disable iff (rst_i) !(lsu_rvalid_i && (r_count == '0))
  );

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Bench for ibex_wb_arbiter: directed plan steps plus random traffic
// checked against a queue-based model of outstanding loads and pending writes.
module tb_ibex_wb_arbiter;

  localparam int MAXL = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_ready_o;
  logic        ld_issue_i;
  logic [4:0]  ld_issue_addr_i;
  logic        ld_issue_ready_o;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic        lsu_err_i;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic        stall_a_o;
  logic        stall_b_o;
  logic [4:0]  waddr_a_o;
  logic [31:0] wdata_a_o;
  logic        we_a_o;
  logic [31:0] rf_rdata_a_i;
  logic [31:0] rf_rdata_b_i;
`ifdef IBEX_WB_FORWARD_EN
  logic [31:0] rdata_a_o;
  logic [31:0] rdata_b_o;
`endif

  int checks = 0;
  int errors = 0;

  ibex_wb_arbiter #(.DataWidth(32), .MaxLoads(MAXL)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .ex_valid_i      (ex_valid_i),
    .ex_waddr_i      (ex_waddr_i),
    .ex_wdata_i      (ex_wdata_i),
    .ex_ready_o      (ex_ready_o),
    .ld_issue_i      (ld_issue_i),
    .ld_issue_addr_i (ld_issue_addr_i),
    .ld_issue_ready_o(ld_issue_ready_o),
    .lsu_rvalid_i    (lsu_rvalid_i),
    .lsu_rdata_i     (lsu_rdata_i),
    .lsu_err_i       (lsu_err_i),
    .raddr_a_i       (raddr_a_i),
    .raddr_b_i       (raddr_b_i),
    .stall_a_o       (stall_a_o),
    .stall_b_o       (stall_b_o),
`ifdef IBEX_WB_FORWARD_EN
    .rf_rdata_a_i    (rf_rdata_a_i),
    .rf_rdata_b_i    (rf_rdata_b_i),
    .rdata_a_o       (rdata_a_o),
    .rdata_b_o       (rdata_b_o),
`endif
    .waddr_a_o       (waddr_a_o),
    .wdata_a_o       (wdata_a_o),
    .we_a_o          (we_a_o)
  );

  always #5 clk = ~clk;

  // Model: loads in flight, execute results parked, expected write port
  logic [4:0]  ldq [$];
  logic [36:0] skq [$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  bit          m_ok = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (ldq[i]) if (ldq[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_skid(input logic [4:0] a);
    return (a != 5'd0) && (skq.size() > 0) && (skq[0][36:32] == a);
  endfunction

  function automatic bit in_out(input logic [4:0] a);
    return (a != 5'd0) && m_we && (m_wa == a);
  endfunction

  function automatic bit exp_stall(input logic [4:0] a);
`ifdef IBEX_WB_FORWARD_EN
    return is_pending(a);
`else
    return is_pending(a) || in_skid(a) || in_out(a);
`endif
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a,
                                            input logic [31:0] rf);
    if (in_out(a)) return m_wd;
    if (in_skid(a)) return skq[0][31:0];
    return rf;
  endfunction

  task automatic idle();
    rst_i = 1'b0;
    ex_valid_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
    ld_issue_i = 1'b0; ld_issue_addr_i = '0;
    lsu_rvalid_i = 1'b0; lsu_rdata_i = '0; lsu_err_i = 1'b0;
    raddr_a_i = '0; raddr_b_i = '0;
    rf_rdata_a_i = $urandom; rf_rdata_b_i = $urandom;
  endtask

  task automatic rand_in(input bit any_rsp);
    ex_valid_i = 1'($urandom_range(0, 1));
    ex_waddr_i = 5'($urandom_range(0, 7));
    ex_wdata_i = $urandom;
    ld_issue_i = ($urandom_range(0, 2) == 0);
    ld_issue_addr_i = 5'($urandom_range(0, 7));
    lsu_rvalid_i = (any_rsp || ldq.size() > 0) && ($urandom_range(0, 1) == 1);
    lsu_rdata_i = $urandom;
    lsu_err_i = ($urandom_range(0, 7) == 0);
    raddr_a_i = 5'($urandom_range(0, 7));
    raddr_b_i = 5'($urandom_range(0, 7));
    rf_rdata_a_i = $urandom;
    rf_rdata_b_i = $urandom;
  endtask

  // One clock: check combinational outputs, advance model, check write port
  task automatic step();
    bit ex_rdy, ld_rdy, ex_acc, ld_acc, rsp, was_rst;
    logic [4:0] h;
    logic [36:0] s;
    #1;
    ex_rdy = (skq.size() == 0) && !(ex_valid_i && is_pending(ex_waddr_i));
    ld_rdy = (ldq.size() < MAXL) && !is_pending(ld_issue_addr_i);
    if (m_ok) begin
      check("ex_ready", 32'(ex_ready_o), 32'(ex_rdy));
      check("ld_ready", 32'(ld_issue_ready_o), 32'(ld_rdy));
      check("stall_a", 32'(stall_a_o), 32'(exp_stall(raddr_a_i)));
      check("stall_b", 32'(stall_b_o), 32'(exp_stall(raddr_b_i)));
`ifdef IBEX_WB_FORWARD_EN
      check("rdata_a", rdata_a_o, exp_rdata(raddr_a_i, rf_rdata_a_i));
      check("rdata_b", rdata_b_o, exp_rdata(raddr_b_i, rf_rdata_b_i));
`endif
    end
    was_rst = rst_i;
    if (rst_i) begin
      ldq.delete(); skq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_ok = 1'b1;
    end else begin
      ex_acc = ex_valid_i && ex_rdy;
      ld_acc = ld_issue_i && ld_rdy;
      rsp = lsu_rvalid_i && (ldq.size() > 0);
      if (rsp) begin
        h = ldq.pop_front();
        m_we = !lsu_err_i && (h != 5'd0); m_wa = h; m_wd = lsu_rdata_i;
        if (ex_acc) skq.push_back({ex_waddr_i, ex_wdata_i});
      end else if (skq.size() > 0) begin
        s = skq.pop_front();
        m_wa = s[36:32]; m_wd = s[31:0]; m_we = (m_wa != 5'd0);
      end else if (ex_acc) begin
        m_wa = ex_waddr_i; m_wd = ex_wdata_i; m_we = (m_wa != 5'd0);
      end else begin
        m_we = 1'b0;
      end
      if (ld_acc) ldq.push_back(ld_issue_addr_i);
    end
    @(posedge clk);
    #1;
    check("we", 32'(we_a_o), 32'(m_we));
    if (m_we || was_rst) begin
      check("waddr", 32'(waddr_a_o), 32'(m_wa));
      check("wdata", wdata_a_o, m_wd);
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    // Reset with random inputs
    rst_i = 1'b1; rand_in(1'b1); step();
    rst_i = 1'b1; rand_in(1'b1); step();
    check("rst_we", 32'(we_a_o), 32'd0);
    check("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    check("rst_ld_ready", 32'(ld_issue_ready_o), 32'd1);
    check("rst_stall_a", 32'(stall_a_o), 32'd0);
    check("rst_stall_b", 32'(stall_b_o), 32'd0);

    // Execute x5
    idle(); ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hDEADBEEF;
    step();
    check("ex5_we", 32'(we_a_o), 32'd1);
    check("ex5_waddr", 32'(waddr_a_o), 32'd5);
    check("ex5_wdata", wdata_a_o, 32'hDEADBEEF);
    idle(); raddr_a_i = 5'd5; #1;
`ifdef IBEX_WB_FORWARD_EN
    check("ex5_stall", 32'(stall_a_o), 32'd0);
    check("ex5_fwd", rdata_a_o, 32'hDEADBEEF);
`else
    check("ex5_stall", 32'(stall_a_o), 32'd1);
`endif
    step();

    // Load x7 response collides with execute x3
    idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd7; step();
    idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h11;
    ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h22; step();
    check("ld7_waddr", 32'(waddr_a_o), 32'd7);
    check("ld7_wdata", wdata_a_o, 32'h11);
    idle(); #1;
    check("skid_ex_ready", 32'(ex_ready_o), 32'd0);
    step();
    check("ex3_we", 32'(we_a_o), 32'd1);
    check("ex3_waddr", 32'(waddr_a_o), 32'd3);
    check("ex3_wdata", wdata_a_o, 32'h22);

    // Load x9 hazards
    idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd9; step();
    idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd9; raddr_b_i = 5'd9;
    ex_valid_i = 1'b1; ex_waddr_i = 5'd9; ex_wdata_i = 32'h5A; #1;
    check("x9_ld_ready", 32'(ld_issue_ready_o), 32'd0);
    check("x9_stall_b", 32'(stall_b_o), 32'd1);
    check("x9_ex_ready", 32'(ex_ready_o), 32'd0);
    step();
    idle(); raddr_b_i = 5'd9; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h99; step();
    idle(); raddr_b_i = 5'd9; #1;
`ifdef IBEX_WB_FORWARD_EN
    check("x9_stall_out", 32'(stall_b_o), 32'd0);
`else
    check("x9_stall_out", 32'(stall_b_o), 32'd1);
`endif
    step();
    idle(); raddr_b_i = 5'd9; #1;
    check("x9_stall_done", 32'(stall_b_o), 32'd0);
    step();

    // MaxLoads limit and error response
    idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd1; step();
    idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd2; step();
    idle(); ld_issue_i = 1'b1; ld_issue_addr_i = 5'd4; #1;
    check("full_ld_ready", 32'(ld_issue_ready_o), 32'd0);
    step();
    idle(); lsu_rvalid_i = 1'b1; lsu_err_i = 1'b1; lsu_rdata_i = 32'hBAD;
    step();
    check("err_we", 32'(we_a_o), 32'd0);
    idle(); raddr_a_i = 5'd1; ld_issue_i = 1'b1; ld_issue_addr_i = 5'd4; #1;
    check("err_x1_clear", 32'(stall_a_o), 32'd0);
    check("x4_ld_ready", 32'(ld_issue_ready_o), 32'd1);
    step();
    idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h2222; step();
    idle(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h4444; step();
    check("x4_wdata", wdata_a_o, 32'h4444);

    // Execute write to x0
    idle(); ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFFFFFF; #1;
    check("x0_ex_ready", 32'(ex_ready_o), 32'd1);
    step();
    check("x0_we", 32'(we_a_o), 32'd0);

    // Back-to-back write then read of x6
    idle(); ex_valid_i = 1'b1; ex_waddr_i = 5'd6; ex_wdata_i = 32'h600D; step();
    idle(); raddr_a_i = 5'd6; step();

    // Random traffic with a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700 || i == 701) begin
        rand_in(1'b1); rst_i = 1'b1;
      end else begin
        rst_i = 1'b0; rand_in(1'b0);
      end
      step();
      if (i == 701) check("midrst_we", 32'(we_a_o), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
